// File: rtl/uart_key_pacer.sv
// uart_key_pacer: FIFO-buffered UART byte pacer that spaces key strobes for the PET keyboard scan.
// Optional CR/LF filter enabled by defining UART_KEY_PACER_LF_FILTER_EN.
module uart_key_pacer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 2500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_strobe,
  input  logic                  hold,
  input  logic                  clr_overflow,
  output logic [7:0]            out_data,
  output logic                  out_strobe,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW = DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  typedef enum logic {IDLE, GAP} state_t;
  state_t state, state_next;
  logic [7:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic full, empty, pop, push, drop, discard;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push = in_strobe && !discard && (!full || pop);
  assign drop = in_strobe && !discard && full && !pop;
`ifdef UART_KEY_PACER_LF_FILTER_EN
  logic [7:0] last;
  assign discard = in_strobe && in_data == 8'h0A && last == 8'h0D;
  // remember the last byte that was not lost to overflow, so an LF right after CR is swallowed once
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last <= 8'h00;
    else if (in_strobe && !drop) last <= in_data;
`else
  assign discard = 1'b0;
`endif
  // issue decision: pop in IDLE when data is waiting and not held; leave GAP when the counter expires
  always_comb begin
    state_next = state;
    pop = 1'b0;
    if (state == IDLE) begin
      pop = !empty && !hold;
      state_next = pop ? GAP : IDLE;
    end else begin
      state_next = (cnt == CW'(1)) ? IDLE : GAP;
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  // gap counter: loaded on issue, counts down through GAP
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (pop) cnt <= GAP_LOAD;
    else if (state == GAP) cnt <= cnt - CW'(1);
  // FIFO pointers and registered fill level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      level <= (push && !pop) ? level + PW'(1) : (pop && !push) ? level - PW'(1) : level;
    end
  // FIFO storage; a full-FIFO push only happens alongside a pop, which reads the old head first
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  // issued byte and its single-cycle strobe; out_data holds between strobes
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_strobe <= 1'b0;
      out_data <= 8'h00;
    end else begin
      out_strobe <= pop;
      out_data <= pop ? mem[rd_ptr[AW-1:0]] : out_data;
    end
  // sticky overflow; a new drop takes priority over a clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
endmodule

// File: tb/tb_uart_key_pacer.sv
// tb_uart_key_pacer: directed self-checking bench for uart_key_pacer with GAP_CYCLES=8, DEPTH_LOG2=2.
module tb_uart_key_pacer;
  logic clk = 0;
  logic reset_n = 1;
  logic [7:0] in_data = 0;
  logic in_strobe = 0;
  logic hold = 0;
  logic clr_overflow = 0;
  logic [7:0] out_data;
  logic out_strobe;
  logic [2:0] level;
  logic overflow;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int peak = 0;
  logic [7:0] cap_d[$];
  int cap_c[$];
  uart_key_pacer #(.DEPTH_LOG2(2), .GAP_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_strobe(in_strobe), .hold(hold),
    .clr_overflow(clr_overflow), .out_data(out_data), .out_strobe(out_strobe), .level(level),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // record every issued byte with the edge count it followed, and the highest level seen
  always @(negedge clk) begin
    if (out_strobe) begin
      cap_d.push_back(out_data);
      cap_c.push_back(cyc);
    end
    if (int'(level) > peak) peak = int'(level);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] b);
    in_data = b;
    in_strobe = 1;
    tick(1);
    in_strobe = 0;
  endtask
  task automatic cap_clear();
    cap_d.delete();
    cap_c.delete();
  endtask
  function automatic logic [31:0] cd(input int i);
    return (i < cap_d.size()) ? {24'h0, cap_d[i]} : 32'hDEAD;
  endfunction
  function automatic logic [31:0] cg(input int i);
    return (i + 1 < cap_c.size()) ? 32'(cap_c[i+1] - cap_c[i]) : 32'hDEAD;
  endfunction
  initial begin
    #2 reset_n = 0;
    #1;
    check("rst_strobe", out_strobe, 0);
    check("rst_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    tick(2);
    reset_n = 1;
    tick(2);
    push(8'h41);
    check("t1_level_k", level, 1);
    check("t1_strobe_k", out_strobe, 0);
    tick(1);
    check("t1_strobe_k1", out_strobe, 1);
    check("t1_data_k1", out_data, 8'h41);
    check("t1_level_k1", level, 0);
    check("t1_ovf", overflow, 0);
    tick(1);
    check("t1_strobe_single", out_strobe, 0);
    check("t1_data_hold", out_data, 8'h41);
    tick(10);
    cap_clear();
    peak = 0;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    tick(30);
    check("t2_count", cap_d.size(), 3);
    check("t2_d0", cd(0), 8'h31);
    check("t2_d1", cd(1), 8'h32);
    check("t2_d2", cd(2), 8'h33);
    check("t2_gap0", cg(0), 8);
    check("t2_gap1", cg(1), 8);
    check("t2_peak", peak, 2);
    cap_clear();
    hold = 1;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    check("t3_level_full", level, 4);
    check("t3_ovf_set", overflow, 1);
    check("t3_held", cap_d.size(), 0);
    hold = 0;
    tick(40);
    check("t3_count", cap_d.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_order", cd(i), 32'hA0 + 32'(i));
    check("t3_level_empty", level, 0);
    check("t3_ovf_sticky", overflow, 1);
    clr_overflow = 1;
    tick(1);
    clr_overflow = 0;
    check("t3_ovf_clr", overflow, 0);
    cap_clear();
    hold = 1;
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    check("t4_level_full", level, 4);
    hold = 0;
    tick(1);
    check("t4_first_strobe", out_strobe, 1);
    check("t4_first_data", out_data, 8'hB0);
    check("t4_level_3", level, 3);
    push(8'hB4);
    check("t4_refill", level, 4);
    tick(6);
    check("t4_gap_quiet", out_strobe, 0);
    in_data = 8'h55;
    in_strobe = 1;
    tick(1);
    in_strobe = 0;
    check("t4_pp_strobe", out_strobe, 1);
    check("t4_pp_data", out_data, 8'hB1);
    check("t4_pp_level", level, 4);
    check("t4_pp_ovf", overflow, 0);
    tick(50);
    check("t4_count", cap_d.size(), 6);
    check("t4_last", cd(5), 8'h55);
    check("t4_b4", cd(4), 8'hB4);
    check("t4_level_end", level, 0);
    hold = 1;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    check("t5_ovf_set", overflow, 1);
    hold = 0;
    tick(1);
    check("t5_strobe_pre", out_strobe, 1);
    check("t5_level_3", level, 3);
    reset_n = 0;
    #1;
    check("t5_rst_strobe", out_strobe, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_level", level, 0);
    check("t5_rst_ovf", overflow, 0);
    tick(3);
    reset_n = 1;
    cap_clear();
    tick(30);
    check("t5_no_strobes", cap_d.size(), 0);
    check("t5_level_after", level, 0);
    push(8'h77);
    check("t5_new_strobe_k", out_strobe, 0);
    tick(1);
    check("t5_new_strobe", out_strobe, 1);
    check("t5_new_data", out_data, 8'h77);
    tick(10);
    cap_clear();
    push(8'h0D);
    push(8'h0A);
    push(8'h0A);
    tick(40);
`ifdef UART_KEY_PACER_LF_FILTER_EN
    check("t6_count", cap_d.size(), 2);
    check("t6_d0", cd(0), 8'h0D);
    check("t6_d1", cd(1), 8'h0A);
`else
    check("t6_count", cap_d.size(), 3);
    check("t6_d0", cd(0), 8'h0D);
    check("t6_d1", cd(1), 8'h0A);
    check("t6_d2", cd(2), 8'h0A);
`endif
    check("t6_ovf", overflow, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
